// File: rtl/ecc_operand_loader.sv
// ---------------------------------------------------------------------------
// ecc_operand_loader
//
// Front-end for the GF(2^163) Montgomery-ladder point multiplier. Collects
// the five 163-bit operands (a, b, k, xp, yp) from 32-bit bus writes, holds
// them stable while the core runs, launches the core with a one-cycle
// core_rst pulse, and times the fixed ladder + inversion latency so that a
// one-cycle done pulse marks the moment xq/yq are valid at the core outputs.
//
// Handshake: a write transfers on any posedge where wr_valid && wr_ready.
// wr_ready is high only in IDLE while start is low, so a start request always
// takes priority over a write in the same cycle. wr_valid may be held high
// while wr_ready is low; the transfer simply waits.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   wr_valid/wr_ready write handshake
//   wr_sel            operand select (0=a,1=b,2=k,3=xp,4=yp; 5..7 illegal)
//   wr_idx            32-bit word index (0..5; 6..7 illegal)
//   wr_data           write data (only [2:0] used for word 5)
//   start             launch request, level-sampled in IDLE
//   abort             cancels LAUNCH/RUN/SETTLE, re-initialising the core
//   a,b,k,xp,yp       registered operands to the core
//   core_rst          core reset/initialise pulse (also high during rst)
//   busy              high in any state other than IDLE
//   done              one-cycle pulse, result valid at the core outputs
//   loaded_mask       bit i set once operand i has been written
//   err               one-cycle pulse on illegal write or rejected start
//   state_dbg         current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module ecc_operand_loader #(
    parameter int LADDER_CYCLES = 162,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [2:0]   wr_sel,
    input  logic [2:0]   wr_idx,
    input  logic [31:0]  wr_data,
    input  logic         start,
    input  logic         abort,
    output logic [162:0] a,
    output logic [162:0] b,
    output logic [162:0] k,
    output logic [162:0] xp,
    output logic [162:0] yp,
    output logic         core_rst,
    output logic         busy,
    output logic         done,
    output logic [4:0]   loaded_mask,
    output logic         err,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Terminal counts: each timed phase exits on the edge where the counter
    // has reached N-1, giving exactly N cycles in the phase.
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(LADDER_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0][162:0] op_q;
    logic [4:0]        mask_q;
    logic              core_rst_q;
    logic              done_q;
    logic              err_q;

    logic wr_fire;
    logic wr_legal;

    assign wr_ready = (state_q == ST_IDLE) && !start;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_legal = (wr_sel <= 3'd4) && (wr_idx <= 3'd5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            mask_q     <= '0;
            core_rst_q <= 1'b1;   // hold the core in reset alongside us
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; the FSM raises them for one cycle.
            core_rst_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            // Writes can only fire in IDLE (wr_ready), which is what keeps
            // the operands frozen from LAUNCH through DONE.
            if (wr_fire) begin
                if (wr_legal) begin
                    case (wr_idx)
                        3'd0:    op_q[wr_sel][31:0]    <= wr_data;
                        3'd1:    op_q[wr_sel][63:32]   <= wr_data;
                        3'd2:    op_q[wr_sel][95:64]   <= wr_data;
                        3'd3:    op_q[wr_sel][127:96]  <= wr_data;
                        3'd4:    op_q[wr_sel][159:128] <= wr_data;
                        // Top word carries only the 3 MSBs of the 163-bit field.
                        3'd5:    op_q[wr_sel][162:160] <= wr_data[2:0];
                        default: ;
                    endcase
                    mask_q[wr_sel] <= 1'b1;
                end else begin
                    // Illegal address: handshake completes, nothing stored.
                    err_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    // abort is deliberately not looked at here.
                    if (start) begin
                        if (&mask_q) begin
                            state_q    <= ST_LAUNCH;
                            core_rst_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                ST_LAUNCH: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        core_rst_q <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        core_rst_q <= 1'b1;
                    end else if (cnt_q == RUN_LAST) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        core_rst_q <= 1'b1;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // Result is being presented; abort is too late to matter.
                ST_DONE: state_q <= ST_IDLE;

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign a           = op_q[0];
    assign b           = op_q[1];
    assign k           = op_q[2];
    assign xp          = op_q[3];
    assign yp          = op_q[4];
    assign loaded_mask = mask_q;
    assign core_rst    = core_rst_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ecc_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_ecc_operand_loader
//
// Directed sequence with randomized operand data. A reference model keeps
// the five operands as plain arrays updated word by word, plus the loaded
// mask; run latency is expected to be 1 + LADDER + SETTLE edges from the
// start edge to the edge that raises done.
// ---------------------------------------------------------------------------
module tb_ecc_operand_loader;

    localparam int L       = 162;
    localparam int S       = 8;
    localparam int RUN_LEN = 1 + L + S;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [2:0]   wr_sel   = '0;
    logic [2:0]   wr_idx   = '0;
    logic [31:0]  wr_data  = '0;
    logic         start    = 1'b0;
    logic         abort    = 1'b0;
    logic [162:0] a, b, k, xp, yp;
    logic         core_rst, busy, done, err;
    logic [4:0]   loaded_mask;
    logic [2:0]   state_dbg;

    ecc_operand_loader #(
        .LADDER_CYCLES(L),
        .SETTLE_CYCLES(S),
        .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
        .start(start), .abort(abort),
        .a(a), .b(b), .k(k), .xp(xp), .yp(yp),
        .core_rst(core_rst), .busy(busy), .done(done),
        .loaded_mask(loaded_mask), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_assert = 0;
    int n_fail   = 0;
    logic [162:0] ref_op [5];
    logic [4:0]   ref_mask;

    task automatic check(input string tag, input logic [162:0] obs, input logic [162:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 5; i++) ref_op[i] = '0;
        ref_mask = '0;
    endtask

    task automatic check_ops(input string tag);
        check({tag, "_a"},    a,  ref_op[0]);
        check({tag, "_b"},    b,  ref_op[1]);
        check({tag, "_k"},    k,  ref_op[2]);
        check({tag, "_xp"},   xp, ref_op[3]);
        check({tag, "_yp"},   yp, ref_op[4]);
        check({tag, "_mask"}, {158'd0, loaded_mask}, {158'd0, ref_mask});
    endtask

    // ---------------- driver tasks ----------------
    // All drivers start and end at #1 after a posedge.
    task automatic do_write(input logic [2:0] sel, input logic [2:0] idx, input logic [31:0] data);
        logic legal;
        legal    = (sel <= 3'd4) && (idx <= 3'd5);
        wr_sel   = sel;
        wr_idx   = idx;
        wr_data  = data;
        wr_valid = 1'b1;
        @(negedge clk);
        check("wr_ready_idle", wr_ready, 1'b1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (legal) begin
            if (idx == 3'd5) ref_op[sel][162:160] = data[2:0];
            else             ref_op[sel][idx*32 +: 32] = data;
            ref_mask[sel] = 1'b1;
        end
        check("err_after_write", err, !legal);
    endtask

    task automatic launch();
        start = 1'b1;
        @(posedge clk);   // E0
        #1;
        start = 1'b0;
    endtask

    // Counts edges after E0 until done rises (bounded), tracking busy and
    // any stray core_rst along the way.
    task automatic wait_done(input int from_edge, output int edges, output logic busy_ok,
                             output logic stray_rst);
        edges     = from_edge;
        busy_ok   = 1'b1;
        stray_rst = 1'b0;
        while (edges < 400) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (core_rst) stray_rst = 1'b1;
        end
    endtask

    task automatic finish_run(input string tag, input int from_edge);
        int   edges;
        logic busy_ok, stray_rst;
        wait_done(from_edge, edges, busy_ok, stray_rst);
        check({tag, "_latency"}, edges, RUN_LEN);
        check({tag, "_busy_run"}, busy_ok, 1'b1);
        check({tag, "_no_core_rst"}, stray_rst, 1'b0);
        check({tag, "_busy_done"}, busy, 1'b1);
        @(posedge clk);
        #1;
        check({tag, "_done_1cyc"}, done, 1'b0);
        check({tag, "_idle_after"}, busy, 1'b0);
    endtask

    task automatic run_full(input string tag);
        launch();
        check({tag, "_core_rst_launch"}, core_rst, 1'b1);
        check({tag, "_busy_launch"}, busy, 1'b1);
        finish_run(tag, 0);
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check(tag, seen, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [2:0] s3, i3;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check_ops("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("core_rst_release", core_rst, 1'b0);

        // Partial load: a, b, xp, yp only
        for (int s = 0; s < 5; s++) begin
            if (s == 2) continue;
            for (int i = 0; i < 6; i++) do_write(3'(s), 3'(i), $urandom);
        end
        check_ops("partial");

        // Rejected start, with a write presented in the same cycle
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_sel   = 3'd2;
        wr_idx   = 3'd0;
        wr_data  = $urandom;
        @(negedge clk);
        check("wr_ready_start_prio", wr_ready, 1'b0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        wr_valid = 1'b0;
        check("rej_err", err, 1'b1);
        check("rej_core_rst", core_rst, 1'b0);
        check("rej_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("rej_err_1cyc", err, 1'b0);
        check("rej_busy_later", busy, 1'b0);
        check_ops("rej");

        // Illegal writes
        do_write(3'd5, 3'd0, $urandom);
        do_write(3'd2, 3'd6, $urandom);
        do_write(3'd7, 3'd7, $urandom);
        @(posedge clk);
        #1;
        check("illegal_err_clear", err, 1'b0);
        check_ops("illegal");

        // Full pattern load
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 6; i++) begin
                s3 = 3'(s);
                i3 = 3'(i);
                do_write(s3, i3, 32'hA5A5_0000 + {26'd0, s3, i3});
            end
        end
        check_ops("pattern");
        check("a_top_bits", a[162:160], 3'b101);
        check("yp_top_bits", yp[162:160], 3'b101);

        // First run, with abort asserted alongside start (start wins)
        abort = 1'b1;
        launch();
        abort = 1'b0;
        check("run1_core_rst_launch", core_rst, 1'b1);
        check("run1_busy_launch", busy, 1'b1);
        finish_run("run1", 0);
        check_ops("run1");

        // Run with a write attempted during RUN
        launch();
        check("run2_core_rst_launch", core_rst, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_sel   = 3'd2;
        wr_idx   = 3'd0;
        wr_data  = $urandom;
        @(negedge clk);
        check("wr_ready_run", wr_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        finish_run("run2", 13);
        check_ops("run2");

        // Rewrite k word 0 only and restart
        do_write(3'd2, 3'd0, $urandom);
        run_full("run3");
        check_ops("run3");

        // Abort at RUN cycle 50
        launch();
        repeat (51) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_core_rst", core_rst, 1'b1);
        check("abort_idle", busy, 1'b0);
        check("abort_no_done", done, 1'b0);
        @(posedge clk);
        #1;
        check("abort_core_rst_1cyc", core_rst, 1'b0);
        expect_no_done("abort_never_done", 200);
        run_full("post_abort");
        check_ops("post_abort");

        // Random word updates followed by full runs
        for (int r = 0; r < 3; r++) begin
            int nw;
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++)
                do_write(3'($urandom_range(0, 4)), 3'($urandom_range(0, 5)), $urandom);
            run_full($sformatf("rand%0d", r));
            check_ops($sformatf("rand%0d", r));
        end

        // Reset asserted at SETTLE cycle 3
        launch();
        repeat (166) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        model_clear();
        check("midrst_core_rst", core_rst, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_err", err, 1'b0);
        check_ops("midrst");
        repeat (2) @(posedge clk);
        #1;
        check("midrst_core_rst_hold", core_rst, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_core_rst_until_edge", core_rst, 1'b1);
        @(posedge clk);
        #1;
        check("midrst_core_rst_release", core_rst, 1'b0);
        expect_no_done("midrst_no_done", 200);
        check("midrst_idle", busy, 1'b0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_operand_loader.md
Name: ecc_operand_loader

Overview:
- Upstream front-end for the GF(2^163) Montgomery-ladder point multiplier.
- Assembles the 163-bit operands a, b, k, xp and yp from 32-bit bus writes using a valid/ready handshake.
- Holds the operands stable and launches the core with a one-cycle core_rst pulse.
- Times the fixed ladder and inversion latency, then signals done so a downstream stage can capture xq/yq.

Parameters:
- LADDER_CYCLES, 162: ladder iterations the core performs after core_rst deasserts (count 0..161).
- SETTLE_CYCLES, 8: extra cycles allowed for the inversion/affine-conversion path to settle before done.
- CNT_W, 8: width of the phase counter; must hold max(LADDER_CYCLES, SETTLE_CYCLES).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- wr_valid, input, 1: write request.
- wr_ready, output, 1: write accepted when wr_valid && wr_ready at a posedge.
- wr_sel, input, 3: operand select (0=a, 1=b, 2=k, 3=xp, 4=yp; 5..7 illegal).
- wr_idx, input, 3: 32-bit word index within the operand (0..5; 6..7 illegal).
- wr_data, input, 32: write data.
- start, input, 1: launch request, level-sampled.
- abort, input, 1: cancel an in-flight operation.
- a, b, k, xp, yp, output, 163 each: registered operands to the core.
- core_rst, output, 1: reset/initialise pulse to the core.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse, result valid on the core outputs.
- loaded_mask, output, 5: bit i set once operand i has been written at least once.
- err, output, 1: one-cycle pulse on an illegal write or a rejected start.

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE.
  - All operand registers, loaded_mask, counter, done and err are 0.
  - core_rst=1 while rst is high, and 0 from the first clock edge after rst falls.
- States:
  - IDLE: accepts writes and start.
  - LAUNCH: exactly 1 cycle; core_rst=1.
  - RUN: LADDER_CYCLES cycles.
  - SETTLE: SETTLE_CYCLES cycles.
  - DONE: 1 cycle; done=1. Then returns to IDLE.
- core_rst is a registered output, high only in LAUNCH (plus during reset).
- wr_ready = (state==IDLE) && !start. start has priority, so a write is never accepted in the start cycle.
- Legal write (sel<=4, idx<=5):
  - idx 0..4: operand[32*idx+31 : 32*idx] <= wr_data.
  - idx 5: operand[162:160] <= wr_data[2:0]; wr_data[31:3] is ignored.
  - Sets loaded_mask[sel]. Re-writes overwrite.
- Illegal write handshake (sel>4 or idx>5): accepted (wr_ready honoured), nothing written, err=1 the next cycle.
- start in IDLE:
  - loaded_mask==5'b11111: go to LAUNCH.
  - Otherwise: err=1 the next cycle and remain in IDLE.
  - start outside IDLE is ignored.
- Timing: start sampled at edge E0. LAUNCH follows E0, RUN follows E1, SETTLE follows E(1+L), DONE follows E(1+L+S). With defaults, done is high in the cycle after edge E0+171.
- Counter: loads 0 on entry to RUN and to SETTLE. The phase exits when counter==N-1.
- Operands are frozen from LAUNCH through DONE. loaded_mask is retained after DONE, so a new run needs only the changed words (e.g. k).
- abort in LAUNCH, RUN or SETTLE:
  - Next state is IDLE and core_rst=1 for that one cycle, re-initialising the core.
  - No done pulse.
  - abort in IDLE or DONE has no effect; DONE still pulses.
- Simultaneous abort and start in IDLE: start wins. abort is ignored in IDLE.

Test Plan:
- Reset then write all 30 words (a,b,k,xp,yp with idx 0..5, data 32'hA5A5_0000+{sel,idx}), start -> core_rst=1 one cycle after the start edge; done pulses exactly 171 edges after the start edge; busy high from LAUNCH through DONE; operand bits [162:160] equal data[2:0] from idx 5.
- Write only a, b, xp, yp, then start -> err pulse one cycle later, no core_rst, state stays IDLE; loaded_mask=5'b11011.
- Write with sel=5 and with idx=6 -> handshake completes, err pulses, all operand values and loaded_mask unchanged.
- Attempt a write during RUN -> wr_ready=0, operands unchanged; then rewrite k word 0 after done and restart -> second done 171 edges after the second start; xp unchanged.
- abort at RUN cycle 50 -> one-cycle core_rst, IDLE next, no done; a subsequent start produces a full-length run.
- Assert rst at SETTLE cycle 3 -> outputs clear immediately, loaded_mask=0, core_rst=1 until after rst falls; no done pulse.
